// File: rtl/daisy_readout_sched_pkg.sv
// Shared types, sizes and helpers for the daisy-chain readout scheduler.
package daisy_readout_sched_pkg;

   localparam int unsigned BLOCK_NUM  = 8;
   localparam int unsigned CH_NUM     = 4;
   localparam int unsigned DATA_W     = 13;
   localparam int unsigned DIV_W      = 16;
   localparam int unsigned CHAIN_LAT  = 2;
   localparam int unsigned FIFO_DEPTH = 4;

   localparam int unsigned BLK_W      = 5;
   localparam int unsigned CH_W       = 3;
   localparam int unsigned TAG_W      = BLK_W + CH_W;
   localparam int unsigned WORDS      = BLOCK_NUM * CH_NUM;
   localparam int unsigned IDX_W      = $clog2(WORDS);
   localparam int unsigned SAMP_CYC   = 2;
   localparam int unsigned LAT_W      = 4;
   localparam int unsigned MIN_P      = WORDS + CHAIN_LAT + 4;
   localparam int unsigned ENTRY_W    = TAG_W + DATA_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMP,
      ST_LAT,
      ST_CAPTURE,
      ST_DONE,
      ST_WAIT
   } state_e;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } entry_t;

   // {block, channel} tag for word index k along the chain.
   function automatic logic [TAG_W-1:0] make_tag(input logic [IDX_W-1:0] k);
      logic [BLK_W-1:0] blk;
      logic [CH_W-1:0]  ch;
      blk = BLK_W'(32'(k) / CH_NUM);
      ch  = CH_W'(32'(k) % CH_NUM);
      return {blk, ch};
   endfunction

   // Frame period clamped so a whole frame always fits between SAMP strobes.
   function automatic logic [DIV_W-1:0] eff_period(input logic [DIV_W-1:0] p);
      return (p < DIV_W'(MIN_P)) ? DIV_W'(MIN_P) : p;
   endfunction

endpackage

// File: rtl/daisy_readout_sched_readout_fifo.sv
// Small synchronous FIFO with registered read port; same-cycle push/pop on full is accepted.
module daisy_readout_sched_readout_fifo
   import daisy_readout_sched_pkg::*;
#(
   parameter int unsigned WIDTH = ENTRY_W,
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid,
   output logic             full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             valid_q, valid_d;
   logic             full_q, full_d;
   logic             do_push, do_pop;

   // Next-state for storage, pointers, occupancy and the registered read port.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_pop   = pop && valid_q;
      do_push  = push && (!full_q || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d     = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      valid_d   = (cnt_d != '0);
      full_d    = (cnt_d == CNT_W'(DEPTH));
      rd_data_d = mem_d[rd_ptr_d];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
         valid_q   <= 1'b0;
         full_q    <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         valid_q   <= valid_d;
         full_q    <= full_d;
      end
   end

   assign rd_data = rd_data_q;
   assign valid   = valid_q;
   assign full    = full_q;

endmodule

// File: rtl/daisy_readout_sched.sv
// Readout scheduler: periodic SAMP strobe, chain latency wait, tagged capture into a buffer.
module daisy_readout_sched
   import daisy_readout_sched_pkg::*;
(
   input  logic              clk_3p2M,
   input  logic              rst,
   input  logic              en,
   input  logic [DIV_W-1:0]  samp_period,
   output logic              SAMP,
   input  logic [DATA_W-1:0] chain_in,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_done,
   output logic              busy,
   output logic              overflow,
   input  logic              clr_ovf
);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             samp_q, samp_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             ovf_q, ovf_d;

   logic             cap_push;
   logic             fifo_valid, fifo_full, fifo_pop, drop;
   entry_t           push_entry, rd_entry;

   // Frame sequencing, period counter and word index; outputs follow the next state.
   always_comb begin
      state_d  = state_q;
      cnt_d    = (cnt_q != '0) ? cnt_q - DIV_W'(1) : '0;
      lat_d    = lat_q;
      idx_d    = idx_q;
      cap_push = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_SAMP;
               cnt_d   = eff_period(samp_period) - DIV_W'(1);
               lat_d   = '0;
            end
         end
         ST_SAMP: begin
            lat_d = lat_q + LAT_W'(1);
            idx_d = '0;
            if (lat_q == LAT_W'(SAMP_CYC - 1)) begin
               state_d = (CHAIN_LAT <= SAMP_CYC) ? ST_CAPTURE : ST_LAT;
            end
         end
         ST_LAT: begin
            lat_d = lat_q + LAT_W'(1);
            idx_d = '0;
            if (lat_q == LAT_W'(CHAIN_LAT - 1)) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            cap_push = 1'b1;
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(WORDS - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               if (en) begin
                  state_d = ST_SAMP;
                  cnt_d   = eff_period(samp_period) - DIV_W'(1);
                  lat_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      samp_d       = (state_d == ST_SAMP);
      busy_d       = (state_d == ST_SAMP) || (state_d == ST_LAT) || (state_d == ST_CAPTURE);
      frame_done_d = (state_d == ST_DONE);
   end

   // Sticky overflow: a drop in the same cycle as clr_ovf keeps it set.
   always_comb begin
      fifo_pop = fifo_valid && out_ready;
      drop     = cap_push && fifo_full && !fifo_pop;
      ovf_d    = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_3p2M) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         lat_q        <= '0;
         idx_q        <= '0;
         samp_q       <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lat_q        <= lat_d;
         idx_q        <= idx_d;
         samp_q       <= samp_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
      end
   end

   assign push_entry = '{tag: make_tag(idx_q), data: chain_in};

   daisy_readout_sched_readout_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_3p2M),
      .rst       (rst),
      .push      (cap_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .rd_data   (rd_entry),
      .valid     (fifo_valid),
      .full      (fifo_full)
   );

   assign SAMP       = samp_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overflow   = ovf_q;
   assign out_valid  = fifo_valid;
   assign out_data   = rd_entry.data;
   assign out_tag    = rd_entry.tag;

endmodule

// File: tb/tb_daisy_readout_sched.sv
// Directed bench for daisy_readout_sched with a chain model and a buffer scoreboard.
module tb_daisy_readout_sched;
   import daisy_readout_sched_pkg::*;

   logic              clk = 1'b0;
   logic              rst, en, clr_ovf;
   logic [DIV_W-1:0]  samp_period;
   logic              samp;
   logic [DATA_W-1:0] chain_in = '0;
   logic [DATA_W-1:0] out_data;
   logic [TAG_W-1:0]  out_tag;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              frame_done, busy, overflow;

   always #5 clk = ~clk;

   daisy_readout_sched dut (
      .clk_3p2M    (clk),
      .rst         (rst),
      .en          (en),
      .samp_period (samp_period),
      .SAMP        (samp),
      .chain_in    (chain_in),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .frame_done  (frame_done),
      .busy        (busy),
      .overflow    (overflow),
      .clr_ovf     (clr_ovf)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [TAG_W-1:0] exp_tag(input int k);
      return TAG_W'((k / 4) * 8 + (k % 4));
   endfunction

   function automatic logic [DATA_W-1:0] exp_word(input int k);
      return DATA_W'(16 * (k / 4) + (k % 4));
   endfunction

   // Monitor / model state
   int                      cyc = 0;
   int                      rel = 1000;
   logic                    samp_prev = 1'b0;
   logic                    ovf_prev = 1'b0;
   int                      rises[$];
   int                      samp_hi = 0;
   int                      fd_cnt = 0;
   int                      n_del = 0;
   int                      ovf_rise_rel = -1;
   logic [TAG_W-1:0]        del_tag[$];
   logic [DATA_W-1:0]       del_data[$];
   logic [ENTRY_W-1:0]      q[$];
   logic                    mdl_ovf = 1'b0;
   int                      sb_bad = 0, vld_bad = 0, ovf_bad = 0;
   int                      rdy_mode = 1;

   // Chain model, consumer, and scoreboard of the output buffer, evaluated mid-cycle.
   always @(negedge clk) begin
      logic pop, drop, cap;
      cyc++;
      if (samp && !samp_prev) begin
         rel = 0;
         rises.push_back(cyc);
      end else if (rel < 1000) begin
         rel++;
      end
      if (samp) samp_hi++;
      samp_prev = samp;
      if (frame_done) fd_cnt++;
      if (overflow && !ovf_prev) ovf_rise_rel = rel;
      ovf_prev = overflow;
      chain_in = (rel >= 2 && rel < 34) ? exp_word(rel - 2) : DATA_W'(13'h1ABC);
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = !out_ready;
      endcase
      if (out_valid !== (q.size() > 0)) vld_bad++;
      if (q.size() > 0 && {out_tag, out_data} !== q[0]) sb_bad++;
      if (overflow !== mdl_ovf) ovf_bad++;
      if (rst) begin
         q.delete();
         mdl_ovf = 1'b0;
         rel = 1000;
      end else begin
         pop = (q.size() > 0) && out_ready;
         if (pop) begin
            void'(q.pop_front());
            del_tag.push_back(out_tag);
            del_data.push_back(out_data);
            n_del++;
         end
         cap  = (rel >= 2 && rel < 34);
         drop = 1'b0;
         if (cap) begin
            if (q.size() < FIFO_DEPTH) q.push_back({exp_tag(rel - 2), exp_word(rel - 2)});
            else drop = 1'b1;
         end
         mdl_ovf = drop ? 1'b1 : (clr_ovf ? 1'b0 : mdl_ovf);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      rises.delete();
      samp_hi = 0;
      fd_cnt = 0;
      n_del = 0;
      ovf_rise_rel = -1;
      del_tag.delete();
      del_data.delete();
   endtask

   task automatic wait_fd(input int n, input int budget);
      int i = 0;
      while (fd_cnt < n && i < budget) begin
         step();
         i++;
      end
      chk("wait_frame_done", 32'(fd_cnt >= n), 1);
   endtask

   task automatic wait_del(input int n, input int budget);
      int i = 0;
      while (n_del < n && i < budget) begin
         step();
         i++;
      end
      chk("wait_delivered", 32'(n_del >= n), 1);
   endtask

   task automatic wait_rel(input int r, input int budget);
      int i = 0;
      while (rel != r && i < budget) begin
         step();
         i++;
      end
      chk("wait_chain_pos", 32'(rel == r), 1);
   endtask

   function automatic int rise_gap(input int i);
      if (rises.size() > i + 1) return rises[i+1] - rises[i];
      return -1;
   endfunction

   function automatic int order_bad();
      int bad = 0;
      for (int i = 0; i < del_tag.size(); i++) begin
         if (del_tag[i] !== exp_tag(i % 32) || del_data[i] !== exp_word(i % 32)) bad++;
      end
      return bad;
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; clr_ovf = 1'b0; samp_period = 16'd100; rdy_mode = 1;
      repeat (3) step();
      chk("rst_samp", samp, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_data", out_data, 0);
      chk("rst_tag", out_tag, 0);
      rst = 1'b0;
      step();

      // 1: nominal period, free-flowing consumer
      clear_stats();
      en = 1'b1;
      wait_fd(3, 400);
      en = 1'b0;
      repeat (5) step();
      chk("t1_rises", rises.size(), 3);
      chk("t1_gap0", rise_gap(0), 100);
      chk("t1_gap1", rise_gap(1), 100);
      chk("t1_samp_width", samp_hi, 6);
      chk("t1_frames", fd_cnt, 3);
      chk("t1_words", n_del, 96);
      chk("t1_order", order_bad(), 0);
      chk("t1_last_tag", (del_tag.size() > 0) ? 32'(del_tag[del_tag.size()-1]) : 32'hFFFF, 32'h3B);
      repeat (110) step();

      // 2: period below minimum is clamped
      clear_stats();
      samp_period = 16'd10;
      en = 1'b1;
      wait_fd(3, 300);
      en = 1'b0;
      repeat (5) step();
      chk("t2_gap0", rise_gap(0), MIN_P);
      chk("t2_gap1", rise_gap(1), MIN_P);
      chk("t2_words", n_del, 96);
      chk("t2_order", order_bad(), 0);
      chk("t2_overflow", overflow, 0);
      repeat (50) step();

      // 3: consumer stalled for a whole frame
      clear_stats();
      rdy_mode = 0;
      samp_period = 16'd100;
      en = 1'b1;
      wait_fd(1, 200);
      en = 1'b0;
      step();
      chk("t3_valid_held", out_valid, 1);
      chk("t3_tag_held", out_tag, 0);
      chk("t3_data_held", out_data, 0);
      chk("t3_overflow", overflow, 1);
      chk("t3_ovf_at_5th", ovf_rise_rel, 7);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("t3_ovf_cleared", overflow, 0);
      rdy_mode = 1;
      wait_del(4, 50);
      repeat (3) step();
      chk("t3_drained_words", n_del, 4);
      chk("t3_drained_order", order_bad(), 0);
      chk("t3_empty", out_valid, 0);
      repeat (100) step();

      // 4: consumer ready every other cycle
      clear_stats();
      rdy_mode = 2;
      samp_period = 16'd200;
      en = 1'b1;
      wait_fd(1, 300);
      en = 1'b0;
      repeat (60) step();
      chk("t4_frames", fd_cnt, 1);
      chk("t4_first_tag", (del_tag.size() > 0) ? 32'(del_tag[0]) : 32'hFFFF, 0);
      chk("t4_drained", out_valid, 0);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      rdy_mode = 1;
      repeat (150) step();

      // 5: reset in the middle of capture
      clear_stats();
      samp_period = 16'd100;
      en = 1'b1;
      wait_rel(11, 100);
      rst = 1'b1;
      step();
      chk("t5_samp", samp, 0);
      chk("t5_busy", busy, 0);
      chk("t5_valid", out_valid, 0);
      chk("t5_frame_done", frame_done, 0);
      step();
      chk("t5_no_done", fd_cnt, 0);
      clear_stats();
      rst = 1'b0;
      wait_fd(1, 200);
      en = 1'b0;
      repeat (5) step();
      chk("t5_words", n_del, 32);
      chk("t5_order", order_bad(), 0);
      repeat (110) step();

      // 6: enable dropped mid-frame
      clear_stats();
      en = 1'b1;
      wait_rel(6, 100);
      en = 1'b0;
      repeat (300) step();
      chk("t6_frames", fd_cnt, 1);
      chk("t6_rises", rises.size(), 1);
      chk("t6_words", n_del, 32);
      chk("t6_order", order_bad(), 0);
      chk("t6_busy", busy, 0);

      chk("buffer_data", sb_bad, 0);
      chk("buffer_valid", vld_bad, 0);
      chk("buffer_overflow", ovf_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
